// File: rtl/pb_cmd_pkg.sv
// Shared types and helpers for the pushbutton command encoder.
package pb_cmd_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, WAIT} pb_state_t;

  localparam int CODE_W = 5;
  localparam logic [CODE_W-1:0] NO_CODE = 5'h1F;

  // Index of the lowest set bit; NO_CODE for an empty vector.
  function automatic logic [CODE_W-1:0] lowest_index(input logic [30:0] vec);
    logic [CODE_W-1:0] code;
    code = NO_CODE;
    for (int unsigned i = 31; i > 0; i--) begin
      if (vec[i-1]) code = CODE_W'(i - 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// Two-flop synchronizer plus stability counter for a vector of raw buttons.
module pb_debounce #(
  parameter int unsigned NBTN     = 21,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic            hz100,
  input  logic            reset,
  input  logic [NBTN-1:0] pb_raw,
  output logic [NBTN-1:0] pb_deb,
  output logic            deb_change
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  logic [NBTN-1:0] sync1;
  logic [NBTN-1:0] sync2;
  logic [CW-1:0]   stable_cnt;

  always_ff @(posedge hz100) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      stable_cnt <= '0;
      pb_deb     <= '0;
      deb_change <= 1'b0;
    end else begin
      sync1      <= pb_raw;
      sync2      <= sync1;
      deb_change <= 1'b0;
      // sync1 != sync2 means sync2 changes at this edge, so the count restarts.
      if (sync1 != sync2) begin
        stable_cnt <= '0;
      end else if (stable_cnt != CW'(DEBOUNCE)) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
      if ((sync2 != pb_deb) && (stable_cnt == CW'(DEBOUNCE))) begin
        pb_deb     <= sync2;
        deb_change <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pb_cmd_encoder.sv
// Debounced, priority-encoded pushbutton command strobes with auto-repeat.
module pb_cmd_encoder
  import pb_cmd_pkg::*;
#(
  parameter int unsigned NBTN        = 21,
  parameter int unsigned DEBOUNCE    = 3,
  parameter int unsigned REPEAT_DLY  = 50,
  parameter int unsigned REPEAT_RATE = 10,
  parameter logic [30:0] REPEAT_MASK = 31'h000900
) (
  input  logic              hz100,
  input  logic              reset,
  input  logic [NBTN-1:0]   pb,
  output logic              cmd_valid,
  output logic [CODE_W-1:0] cmd_code,
  output logic              cmd_repeat,
  output logic              multi,
  output logic              held
);

  localparam int unsigned TMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  logic [NBTN-1:0]   pb_deb;
  logic              deb_change;
  logic [CODE_W-1:0] code_nxt;
  logic              any_set;
  logic              multi_nxt;
  logic              rep_btn;
  logic [31:0]       mask_ext;

  pb_state_t         state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic              strobe_nxt;
  logic              repeat_nxt;

  pb_debounce #(
    .NBTN     (NBTN),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .hz100      (hz100),
    .reset      (reset),
    .pb_raw     (pb),
    .pb_deb     (pb_deb),
    .deb_change (deb_change)
  );

  always_comb begin
    mask_ext  = {1'b0, REPEAT_MASK};
    code_nxt  = lowest_index(31'(pb_deb));
    any_set   = |pb_deb;
    multi_nxt = |(pb_deb & (pb_deb - 1'b1));
    rep_btn   = any_set && mask_ext[code_nxt];
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    strobe_nxt = 1'b0;
    repeat_nxt = 1'b0;
    if ((state == HOLD) && (timer != '0)) begin
      timer_nxt = timer - 1'b1;
    end
    // A debounced change pre-empts any pending repeat; reloads override the decrement.
    if (deb_change) begin
      if (!any_set) begin
        state_nxt = IDLE;
      end else begin
        strobe_nxt = 1'b1;
        timer_nxt  = TW'(REPEAT_DLY);
        state_nxt  = rep_btn ? HOLD : WAIT;
      end
    end else begin
      case (state)
        HOLD: begin
          if (timer == TW'(1)) begin
            strobe_nxt = 1'b1;
            repeat_nxt = 1'b1;
            timer_nxt  = TW'(REPEAT_RATE);
          end
        end
        WAIT: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      cmd_valid  <= 1'b0;
      cmd_repeat <= 1'b0;
      cmd_code   <= NO_CODE;
      multi      <= 1'b0;
      held       <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      cmd_valid  <= strobe_nxt;
      cmd_repeat <= repeat_nxt;
      cmd_code   <= code_nxt;
      multi      <= multi_nxt;
      held       <= any_set;
    end
  end

endmodule

// File: tb/tb_pb_cmd_encoder.sv
// Directed bench for pb_cmd_encoder: strobe timing, codes, repeat and reset behaviour.
module tb_pb_cmd_encoder;

  logic        hz100;
  logic        reset;
  logic [20:0] pb;
  logic        cmd_valid;
  logic [4:0]  cmd_code;
  logic        cmd_repeat;
  logic        multi;
  logic        held;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  code;
    logic        rep;
    logic        multi;
    logic        held;
  } strobe_t;

  strobe_t log_q[$];

  pb_cmd_encoder #(
    .NBTN        (21),
    .DEBOUNCE    (3),
    .REPEAT_DLY  (50),
    .REPEAT_RATE (10),
    .REPEAT_MASK (31'h000900)
  ) dut (
    .hz100      (hz100),
    .reset      (reset),
    .pb         (pb),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_repeat (cmd_repeat),
    .multi      (multi),
    .held       (held)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  always @(posedge hz100) cyc <= cyc + 1;

  always @(negedge hz100) begin
    if (cmd_valid === 1'b1) log_q.push_back('{cyc, cmd_code, cmd_repeat, multi, held});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge hz100);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"},  32'(cmd_valid),  32'd0);
    check({tag, ".code"},   32'(cmd_code),   32'h1F);
    check({tag, ".repeat"}, 32'(cmd_repeat), 32'd0);
    check({tag, ".multi"},  32'(multi),      32'd0);
    check({tag, ".held"},   32'(held),       32'd0);
  endtask

  int unsigned t0;
  int unsigned exp_cyc;

  initial begin
    reset = 1'b1;
    pb    = '1;

    // 1: reset with all buttons pressed
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_reset_outputs("rst");
    end
    check("rst.no_strobe", 32'(log_q.size()), 32'd0);
    pb    = '0;
    reset = 1'b0;
    tick(10);
    check("idle.no_strobe", 32'(log_q.size()), 32'd0);
    log_q.delete();

    // 2: single non-repeat press and release
    pb[2] = 1'b1;
    t0 = cyc + 1;
    tick(20);
    check("p2.count", 32'(log_q.size()), 32'd1);
    if (log_q.size() >= 1) begin
      check("p2.cyc",    log_q[0].cyc,          t0 + 6);
      check("p2.code",   32'(log_q[0].code),    32'd2);
      check("p2.repeat", 32'(log_q[0].rep),     32'd0);
      check("p2.held",   32'(log_q[0].held),    32'd1);
    end
    check("p2.held_lvl", 32'(held), 32'd1);
    pb[2] = 1'b0;
    tick(6);
    check("p2.held_before_fall", 32'(held), 32'd1);
    tick(1);
    check("p2.held_fall", 32'(held), 32'd0);
    tick(5);
    check("p2.release_no_strobe", 32'(log_q.size()), 32'd1);
    log_q.delete();

    // 3: glitch shorter than the debounce window
    pb[5] = 1'b1;
    tick(2);
    pb[5] = 1'b0;
    tick(12);
    check("glitch.count", 32'(log_q.size()), 32'd0);
    check("glitch.held",  32'(held),         32'd0);
    log_q.delete();

    // 4: auto-repeat on pb[8]
    pb[8] = 1'b1;
    t0 = cyc + 1;
    tick(200);
    pb[8] = 1'b0;
    tick(20);
    check("rep.count", 32'(log_q.size()), 32'd16);
    for (int i = 0; i < log_q.size(); i++) begin
      exp_cyc = (i == 0) ? t0 + 6 : t0 + 56 + 10 * (i - 1);
      check($sformatf("rep[%0d].cyc", i),    log_q[i].cyc,       exp_cyc);
      check($sformatf("rep[%0d].repeat", i), 32'(log_q[i].rep),  (i == 0) ? 32'd0 : 32'd1);
      check($sformatf("rep[%0d].code", i),   32'(log_q[i].code), 32'd8);
    end
    check("rep.held_after", 32'(held), 32'd0);
    log_q.delete();

    // 5: two buttons, then drop the lower one
    pb[3] = 1'b1;
    pb[9] = 1'b1;
    t0 = cyc + 1;
    tick(12);
    check("mb.count1", 32'(log_q.size()), 32'd1);
    if (log_q.size() >= 1) begin
      check("mb.cyc1",   log_q[0].cyc,        t0 + 6);
      check("mb.code1",  32'(log_q[0].code),  32'd3);
      check("mb.multi1", 32'(log_q[0].multi), 32'd1);
    end
    pb[3] = 1'b0;
    t0 = cyc + 1;
    tick(12);
    check("mb.count2", 32'(log_q.size()), 32'd2);
    if (log_q.size() >= 2) begin
      check("mb.cyc2",    log_q[1].cyc,        t0 + 6);
      check("mb.code2",   32'(log_q[1].code),  32'd9);
      check("mb.multi2",  32'(log_q[1].multi), 32'd0);
      check("mb.repeat2", 32'(log_q[1].rep),   32'd0);
    end
    pb = '0;
    tick(12);
    log_q.delete();

    // 6: reset during an auto-repeat hold
    pb[11] = 1'b1;
    t0 = cyc + 1;
    tick(36);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("mid_rst1");
    tick(1);
    check_reset_outputs("mid_rst2");
    check("mid_rst.count", 32'(log_q.size()), 32'd1);
    if (log_q.size() >= 1) check("mid_rst.first_cyc", log_q[0].cyc, t0 + 6);
    reset = 1'b0;
    t0 = cyc + 1;
    tick(12);
    check("post_rst.count", 32'(log_q.size()), 32'd2);
    if (log_q.size() >= 2) begin
      check("post_rst.cyc",    log_q[1].cyc,       t0 + 6);
      check("post_rst.code",   32'(log_q[1].code), 32'd11);
      check("post_rst.repeat", 32'(log_q[1].rep),  32'd0);
    end
    pb = '0;
    tick(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
